// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared FSM state types and constants for the uart stream bridge
package uart_bridge_pkg;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ACK  = 1'b1
  } rx_state_t;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_HOLD = 1'b1
  } tx_state_t;

  localparam logic [7:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with explicit occupancy counter
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_valid,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  input  logic             i_rd_ready,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_level == LVL_FULL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_push    = i_wr_valid && !o_full;
  assign w_pop     = i_rd_ready && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_stream_bridge.sv
// rtl/uart_stream_bridge.sv - valid/ready byte streams over the uart core's rx/tx handshakes
module uart_stream_bridge
  import uart_bridge_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    uart_rx_data,
  input  logic          uart_rx_avail,
  input  logic          uart_rx_error,
  output logic          uart_rx_ack,
  output logic [7:0]    uart_tx_data,
  output logic          uart_tx_wr,
  input  logic          uart_tx_busy,
  output logic [7:0]    m_rx_data,
  output logic          m_rx_valid,
  input  logic          m_rx_ready,
  input  logic [7:0]    s_tx_data,
  input  logic          s_tx_valid,
  output logic          s_tx_ready,
  output logic [AW:0]   rx_level,
  output logic [AW:0]   tx_level,
  output logic [7:0]    rx_err_count,
  output logic          rx_overflow,
  input  logic          clear_status
);

  rx_state_t  r_rx_state, w_rx_state_nxt;
  tx_state_t  r_tx_state, w_tx_state_nxt;
  logic       w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
  logic [7:0] w_tx_head;
  logic       w_rx_take, w_rx_ack_d, w_err_inc, w_ovf_set, w_tx_issue;
  logic       r_rx_ack, r_tx_wr, r_overflow;
  logic [7:0] r_tx_data, r_err_count;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset),
    .i_wr_valid(w_rx_take), .i_wr_data(uart_rx_data), .o_full(w_rx_full),
    .i_rd_ready(m_rx_ready), .o_rd_data(m_rx_data), .o_empty(w_rx_empty),
    .o_level(rx_level)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset),
    .i_wr_valid(s_tx_valid), .i_wr_data(s_tx_data), .o_full(w_tx_full),
    .i_rd_ready(w_tx_issue), .o_rd_data(w_tx_head), .o_empty(w_tx_empty),
    .o_level(tx_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= R_IDLE;
      r_tx_state <= T_IDLE;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_tx_state <= w_tx_state_nxt;
    end
  end

  // R_ACK is a one-cycle guard: the core still shows avail while it absorbs the ack
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      R_IDLE:  if (uart_rx_avail || uart_rx_error) w_rx_state_nxt = R_ACK;
      R_ACK:   w_rx_state_nxt = R_IDLE;
      default: w_rx_state_nxt = R_IDLE;
    endcase
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      T_IDLE:  if (!w_tx_empty && !uart_tx_busy) w_tx_state_nxt = T_HOLD;
      T_HOLD:  if (uart_tx_busy) w_tx_state_nxt = T_IDLE;
      default: w_tx_state_nxt = T_IDLE;
    endcase
  end

  always_comb begin
    w_rx_take  = 1'b0;
    w_rx_ack_d = 1'b0;
    w_err_inc  = 1'b0;
    w_ovf_set  = 1'b0;
    w_tx_issue = 1'b0;
    if (r_rx_state == R_IDLE) begin
      w_rx_ack_d = uart_rx_avail || uart_rx_error;
      w_rx_take  = uart_rx_avail && !w_rx_full;
      w_ovf_set  = uart_rx_avail && w_rx_full;
      w_err_inc  = !uart_rx_avail && uart_rx_error;
    end
    if (r_tx_state == T_IDLE) w_tx_issue = !w_tx_empty && !uart_tx_busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_ack  <= 1'b0;
      r_tx_wr   <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_rx_ack <= w_rx_ack_d;
      r_tx_wr  <= w_tx_issue;
      if (w_tx_issue) r_tx_data <= w_tx_head;
    end
  end

  // clear wins over a same-cycle increment or overflow
  always_ff @(posedge clk) begin
    if (reset || clear_status) begin
      r_err_count <= 8'h00;
      r_overflow  <= 1'b0;
    end else begin
      if (w_err_inc && r_err_count != ERR_MAX) r_err_count <= r_err_count + 8'd1;
      if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  assign uart_rx_ack  = r_rx_ack;
  assign uart_tx_wr   = r_tx_wr;
  assign uart_tx_data = r_tx_data;
  assign m_rx_valid   = !w_rx_empty;
  assign s_tx_ready   = !w_tx_full;
  assign rx_err_count = r_err_count;
  assign rx_overflow  = r_overflow;

endmodule

// File: tb/tb_uart_stream_bridge.sv
// tb/tb_uart_stream_bridge.sv - randomized scoreboard bench for uart_stream_bridge
module tb_uart_stream_bridge;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    uart_rx_data = 8'h00;
  logic          uart_rx_avail = 1'b0;
  logic          uart_rx_error = 1'b0;
  logic          uart_rx_ack;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_wr;
  logic          uart_tx_busy;
  logic [7:0]    m_rx_data;
  logic          m_rx_valid;
  logic          m_rx_ready = 1'b0;
  logic [7:0]    s_tx_data = 8'h00;
  logic          s_tx_valid = 1'b0;
  logic          s_tx_ready;
  logic [AW:0]   rx_level;
  logic [AW:0]   tx_level;
  logic [7:0]    rx_err_count;
  logic          rx_overflow;
  logic          clear_status = 1'b0;

  logic busy_core = 1'b0;
  logic busy_force = 1'b0;
  int   busy_len = 20;
  assign uart_tx_busy = busy_core | busy_force;

  int vectors = 0;
  int miscompares = 0;

  // reference model state: queues of expected bytes plus occupancy/status as plain numbers
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  int   rx_occ = 0, tx_occ = 0, exp_err = 0, wr_count = 0;
  bit   exp_ovf = 0, busy_seen = 1;
  bit   rx_pop_pending = 0, tx_push_pending = 0;
  logic prev_reset = 1'b1, prev_avail = 1'b0, prev_err = 1'b0, prev_clr = 1'b0;
  logic prev_ack = 1'b0, prev_wr = 1'b0, prev_busy = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_stream_bridge #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .uart_rx_data(uart_rx_data), .uart_rx_avail(uart_rx_avail), .uart_rx_error(uart_rx_error),
    .uart_rx_ack(uart_rx_ack), .uart_tx_data(uart_tx_data), .uart_tx_wr(uart_tx_wr),
    .uart_tx_busy(uart_tx_busy), .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid),
    .m_rx_ready(m_rx_ready), .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid),
    .s_tx_ready(s_tx_ready), .rx_level(rx_level), .tx_level(tx_level),
    .rx_err_count(rx_err_count), .rx_overflow(rx_overflow), .clear_status(clear_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core-side model: busy rises the cycle after a write strobe and stays up busy_len cycles
  always begin
    @(negedge clk);
    if (uart_tx_wr) begin
      @(posedge clk);
      #1 busy_core = 1'b1;
      repeat (busy_len) @(posedge clk);
      #1 busy_core = 1'b0;
    end
  end

  // Reference model: inputs seen at negedge are what the next edge sees; the ack that follows
  // an edge says the core's event was consumed at that edge.
  always @(negedge clk) begin
    int pushed;
    pushed = 0;
    if (prev_reset) begin
      exp_rx.delete();
      exp_tx.delete();
      rx_occ = 0; tx_occ = 0; exp_err = 0; exp_ovf = 0; busy_seen = 1;
      check("rst_ack", uart_rx_ack, 0);
      check("rst_wr", uart_tx_wr, 0);
      check("rst_tx_data", uart_tx_data, 0);
    end else begin
      if (uart_rx_ack) begin
        check("ack_single_cycle", prev_ack, 0);
        if (prev_avail) begin
          if (rx_occ == DEPTH) exp_ovf = 1;
          else begin
            exp_rx.push_back(prev_data);
            pushed = 1;
          end
        end else if (prev_err) begin
          if (exp_err < 255) exp_err++;
        end else begin
          check("ack_spurious", uart_rx_ack, 0);
        end
      end
      if (prev_clr) begin
        exp_err = 0;
        exp_ovf = 0;
      end
      rx_occ = rx_occ + pushed - int'(rx_pop_pending);
      tx_occ = tx_occ + int'(tx_push_pending) - int'(uart_tx_wr);
      if (uart_tx_wr) begin
        wr_count++;
        check("wr_single_cycle", prev_wr, 0);
        check("wr_while_busy", prev_busy, 0);
        check("wr_needs_busy_between", busy_seen, 1);
        busy_seen = 0;
      end
      if (uart_tx_busy) busy_seen = 1;
    end
    check("rx_level", rx_level, rx_occ);
    check("tx_level", tx_level, tx_occ);
    check("m_rx_valid", m_rx_valid, rx_occ > 0);
    check("s_tx_ready", s_tx_ready, tx_occ < DEPTH);
    check("rx_err_count", rx_err_count, exp_err);
    check("rx_overflow", rx_overflow, exp_ovf);
    rx_pop_pending  = !reset && m_rx_ready && (rx_occ > 0);
    tx_push_pending = !reset && s_tx_valid && (tx_occ < DEPTH);
    if (tx_push_pending) exp_tx.push_back(s_tx_data);
    prev_reset = reset;
    prev_avail = uart_rx_avail;
    prev_err   = uart_rx_error;
    prev_data  = uart_rx_data;
    prev_clr   = clear_status;
    prev_ack   = uart_rx_ack;
    prev_wr    = uart_tx_wr;
    prev_busy  = uart_tx_busy;
  end

  // RX stream monitor: head must match the oldest expected byte; pop on a transfer
  always @(negedge clk) begin
    #1;
    if (m_rx_valid) begin
      if (exp_rx.size() == 0) check("rx_unexpected_valid", m_rx_valid, 0);
      else begin
        check("rx_data", m_rx_data, exp_rx[0]);
        if (m_rx_ready && !reset) void'(exp_rx.pop_front());
      end
    end
  end

  // TX core-side monitor: every write strobe carries the oldest accepted stream byte
  always @(negedge clk) begin
    #1;
    if (uart_tx_wr) begin
      if (exp_tx.size() == 0) check("tx_unexpected_wr", uart_tx_wr, 0);
      else check("tx_data", uart_tx_data, exp_tx.pop_front());
    end
  end

  // Core RX handshake: hold the byte/error until ack, drop it one cycle later
  task automatic rx_offer(input logic av, input logic er, input logic [7:0] d);
    int n;
    n = 0;
    uart_rx_avail = av;
    uart_rx_error = er;
    uart_rx_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!uart_rx_ack && n < 12);
    check("ack_timeout", uart_rx_ack, 1);
    @(posedge clk);
    #1;
    uart_rx_avail = 1'b0;
    uart_rx_error = 1'b0;
    tick();
  endtask

  task automatic tx_send(input logic [7:0] d);
    int n;
    n = 0;
    s_tx_valid = 1'b1;
    s_tx_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tx_ready && n < 400);
    check("tx_send_timeout", s_tx_ready, 1);
    @(posedge clk);
    #1;
    s_tx_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    m_rx_ready = 1'b1;
    while ((rx_occ != 0 || tx_occ != 0 || busy_core || uart_tx_wr) && n < 3000) begin
      tick();
      n++;
    end
    check("idle_timeout", n < 3000, 1);
    m_rx_ready = 1'b0;
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int n, w0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_s_tx_ready", s_tx_ready, 1);
    check("rst_m_rx_valid", m_rx_valid, 0);
    check("rst_rx_level", rx_level, 0);
    tick();

    rx_offer(1'b1, 1'b0, 8'hA5);
    @(negedge clk);
    check("a5_level", rx_level, 1);
    check("a5_data", m_rx_data, 8'hA5);
    check("a5_valid", m_rx_valid, 1);
    tick();
    m_rx_ready = 1'b1;
    tick();
    m_rx_ready = 1'b0;
    @(negedge clk);
    check("a5_popped", rx_level, 0);
    tick();

    for (int i = 0; i < 17; i++) rx_offer(1'b1, 1'b0, 8'(i));
    @(negedge clk);
    check("ovf_level", rx_level, 16);
    check("ovf_flag", rx_overflow, 1);
    tick();
    wait_idle();
    pulse_clear();
    @(negedge clk);
    check("ovf_cleared", rx_overflow, 0);
    tick();

    repeat (300) rx_offer(1'b0, 1'b1, 8'h00);
    @(negedge clk);
    check("err_saturated", rx_err_count, 255);
    tick();
    rx_offer(1'b1, 1'b1, 8'h5A);
    @(negedge clk);
    check("avail_err_count", rx_err_count, 255);
    check("avail_err_level", rx_level, 1);
    check("avail_err_data", m_rx_data, 8'h5A);
    tick();
    wait_idle();
    pulse_clear();

    busy_len = 20;
    w0 = wr_count;
    tx_send(8'h11);
    tx_send(8'h22);
    tx_send(8'h33);
    wait_idle();
    check("burst_wr_pulses", wr_count - w0, 3);

    busy_len = 3;
    busy_force = 1'b1;
    for (int i = 0; i < 16; i++) tx_send(8'hC0 + 8'(i));
    s_tx_valid = 1'b1;
    s_tx_data  = 8'hEE;
    repeat (3) tick();
    @(negedge clk);
    check("full_ready", s_tx_ready, 0);
    check("full_level", tx_level, 16);
    @(posedge clk);
    #1 busy_force = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tx_ready && n < 50);
    check("full_ready_rises", s_tx_ready, 1);
    @(posedge clk);
    #1 s_tx_valid = 1'b0;
    wait_idle();

    fork
      begin
        repeat (120) begin
          logic av, er;
          av = ($urandom_range(0, 3) != 0);
          er = av ? ($urandom_range(0, 2) == 0) : 1'b1;
          rx_offer(av, er, 8'($urandom));
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin
        repeat (120) begin
          tx_send(8'($urandom));
          repeat ($urandom_range(0, 4)) tick();
        end
      end
      begin
        for (int c = 0; c < 1500; c++) begin
          m_rx_ready   = (c < 700) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
          clear_status = ($urandom_range(0, 63) == 0);
          tick();
        end
        m_rx_ready   = 1'b0;
        clear_status = 1'b0;
      end
    join
    wait_idle();

    pulse_clear();
    busy_force = 1'b1;
    rx_offer(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) tx_send(8'h40 + 8'(i));
    @(negedge clk);
    check("mid_tx_level", tx_level, 5);
    check("mid_err", rx_err_count, 1);
    tick();
    uart_rx_avail = 1'b1;
    uart_rx_data  = 8'h77;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!uart_rx_ack && n < 12);
    check("mid_ack", uart_rx_ack, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    uart_rx_avail = 1'b0;
    busy_force = 1'b0;
    @(negedge clk);
    check("post_rst_rx_level", rx_level, 0);
    check("post_rst_tx_level", tx_level, 0);
    check("post_rst_ack", uart_rx_ack, 0);
    check("post_rst_wr", uart_tx_wr, 0);
    check("post_rst_err", rx_err_count, 0);
    check("post_rst_ovf", rx_overflow, 0);
    check("post_rst_ready", s_tx_ready, 1);
    tick();
    rx_offer(1'b1, 1'b0, 8'h3C);
    @(negedge clk);
    check("post_rst_rx_byte", m_rx_data, 8'h3C);
    tick();
    tx_send(8'h99);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_stream_bridge.md
Name: uart_stream_bridge

Overview:
Sits between the uart core and the fabric-side logic. It converts the core's level-style RX interface (rx_avail/rx_ack) and its busy-gated TX interface (tx_wr/tx_busy) into valid/ready byte streams. Each direction has its own FIFO, so bursts are absorbed without byte loss while the FIFO has room. It also keeps error and overflow status for software.

Parameters:
DEPTH, 16, entries per FIFO; must be a power of 2 and at least 2.
AW, $clog2(DEPTH), FIFO pointer width (derived, do not override).

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
uart_rx_data  in  8  received byte from core
uart_rx_avail  in  1  core holds a valid byte
uart_rx_error  in  1  core saw a bad stop bit
uart_rx_ack  out  1  single-cycle ack to core, registered
uart_tx_data  out  8  byte to core, registered
uart_tx_wr  out  1  single-cycle write strobe to core, registered
uart_tx_busy  in  1  core transmitting
m_rx_data  out  8  RX stream data (FIFO head)
m_rx_valid  out  1  RX FIFO not empty
m_rx_ready  in  1  consumer accepts
s_tx_data  in  8  TX stream data
s_tx_valid  in  1  producer offers a byte
s_tx_ready  out  1  TX FIFO not full
rx_level  out  AW+1  RX FIFO occupancy
tx_level  out  AW+1  TX FIFO occupancy
rx_err_count  out  8  framing errors, saturates at 255
rx_overflow  out  1  sticky: a byte was dropped because the RX FIFO was full
clear_status  in  1  clears rx_err_count and rx_overflow

Behaviour:
- Reset: all outputs 0, both FIFOs empty, both FSMs in IDLE. s_tx_ready=1 in the first cycle after reset.
- FIFO: show-ahead. Head data is valid combinationally whenever not empty. A push happens on valid&&!full; a pop happens on ready&&!empty. A push and a pop in the same cycle leave the level unchanged. Pointers wrap modulo DEPTH. Level is kept as an explicit AW+1 counter that reaches DEPTH when full.
- Stream handshakes: m_rx_valid = !rx_empty. s_tx_ready = !tx_full. A transfer occurs on valid&&ready at the clock edge.
- RX FSM, states R_IDLE and R_ACK:
  - R_IDLE, uart_rx_avail=1: push uart_rx_data if the FIFO is not full; otherwise drop the byte and set rx_overflow. A full-FIFO push is dropped even when a pop occurs in the same cycle. Register uart_rx_ack=1 and go to R_ACK.
  - R_IDLE, uart_rx_error=1 with avail=0: increment rx_err_count (saturating), register ack, go to R_ACK.
  - If avail and error are both high, avail takes priority and the error is not counted.
  - R_ACK: ack returns to 0 and the FSM returns to R_IDLE unconditionally. This one-cycle guard covers the core's one-cycle ack latency, so a single byte is never pushed twice.
  - Result: ack is high for exactly 1 cycle, 1 cycle after avail is first seen.
- TX FSM, states T_IDLE and T_HOLD:
  - T_IDLE: when !tx_empty && !uart_tx_busy, register uart_tx_data=head and uart_tx_wr=1, pop, go to T_HOLD.
  - T_HOLD: uart_tx_wr returns to 0. Stay until uart_tx_busy=1, then go to T_IDLE.
  - Result: never two tx_wr pulses without an intervening busy rise. Back-to-back bytes are issued in the first T_IDLE cycle after busy falls.
- Status:
  - clear_status has priority over a same-cycle increment or set; the result is 0.
  - rx_err_count holds at 255 once saturated.
- Reset mid-operation: FIFO contents are discarded and the FSMs return to IDLE. A byte already handed to the core is still transmitted by the core; the bridge does not track it.

Decomposition:
- Package uart_bridge_pkg holds:
  - rx_state_t (R_IDLE, R_ACK)
  - tx_state_t (T_IDLE, T_HOLD)
  - ERR_MAX=8'hFF
- One sub-module, sync_fifo (params WIDTH, DEPTH), instantiated twice: 8-bit RX and 8-bit TX.
- FSMs and status counters live in the top module.

Test Plan:
- RX single byte: avail=1 with data 0xA5 held until ack → exactly one ack pulse, rx_level=1, m_rx_data=0xA5, m_rx_valid=1. Pop → level 0.
- RX overflow: DEPTH=16, push 17 bytes 0x00..0x10 with m_rx_ready=0 → 17 acks, level 16, rx_overflow=1, FIFO drains 0x00..0x0F in order. Then clear_status → rx_overflow=0.
- RX errors: 300 error-only events → rx_err_count=255. Event with avail=1 and error=1 → byte pushed, count unchanged.
- TX burst: write 0x11,0x22,0x33 back-to-back, with a core model (busy the cycle after wr, for 20 cycles) → three single-cycle tx_wr pulses carrying 0x11,0x22,0x33, each issued while busy=0, never while busy=1.
- TX full: 16 writes with busy stuck high → s_tx_ready=0, tx_level=16. 17th offer not accepted. Release busy → drains and ready rises.
- Reset mid-burst: tx_level=5 and RX FSM in R_ACK, assert reset for 1 cycle → all levels 0, ack/wr 0, FSMs back in IDLE, status cleared.
